bram_bus_arbiter: RTL and testbench
===================================

// Module: bram_bus_arbiter
// PURPOSE
//  Two-master to one-slave Wishbone-classic arbiter in front of the on-chip BRAM.
//  Shares the BRAM port between the core's instruction-fetch master (i*) and data master (d*).
//  Sits between core and BRAM: grants one master at a time, muxes its request onto the BRAM (m*), routes ack/err/data back.
// PARAMETERS
//  AW          32   address width, all ports
//  DW          32   data width, all ports
//  SW          4    byte-select width (DW/8)
//  TIMEOUT_CYC 16   cycles without ack before forced error (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    reset; asynchronous, active-high
//  iaddr_i/daddr_i  in  AW  master address (instr/data)
//  idat_i/ddat_i    in  DW  master write data
//  isel_i/dsel_i    in  SW  master byte selects
//  icyc_i/dcyc_i    in  1   master cycle (bus request/lock)
//  istb_i/dstb_i    in  1   master strobe
//  iwe_i/dwe_i      in  1   master write enable
//  idat_o/ddat_o    out DW  read data to master
//  iack_o/dack_o    out 1   ack to master
//  ierr_o/derr_o    out 1   error to master
//  maddr_o,mdat_o,msel_o,mcyc_o,mstb_o,mwe_o  out  AW/DW/SW/1/1/1  request to BRAM
//  mdat_i,mack_i,merr_i                       in   DW/1/1          response from BRAM
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, last_gnt=I (data wins first tie), timeout cnt=0; all outputs 0.
//  - FSM states: IDLE, GNT_I, GNT_D; state register only, mux/routing combinational from state.
//  - IDLE: m* outputs 0. Request = cyc&stb. Only one requesting -> grant it next cycle.
//    Both requesting -> grant the one NOT in last_gnt; last_gnt updated on every grant.
//  - Arbitration latency: 1 cycle (request seen in IDLE, m* driven from next cycle).
//  - GNT_x: m{addr,dat,sel,cyc,stb,we}_o = granted master's inputs; {x}ack_o=mack_i, {x}err_o=merr_i;
//    non-granted master ack/err = 0. mdat_i drives both idat_o and ddat_o (only acked master samples).
//  - Grant held while granted master keeps cyc=1 (back-to-back/burst strobes allowed, no re-arbitration).
//  - Granted cyc=0 -> IDLE next cycle; mcyc_o/mstb_o drop same cycle (combinational). 1 idle cycle min between grants.
//  - Other master's request during a grant: ignored, remains pending; never starved beyond one transaction
//    when both keep requesting (alternation via last_gnt).
//  - mack_i/merr_i while IDLE: discarded, not forwarded.
//  - mack_i and merr_i both 1: forward both; master treats err as dominant.
//  - Reset mid-transaction: immediate IDLE, mcyc_o=0; in-flight BRAM response discarded.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: counter increments each GNT cycle with mstb_o=1 and mack_i=merr_i=0;
//    cleared on ack/err/IDLE. At cnt==TIMEOUT_CYC-1: one-cycle {x}err_o=1 to granted master,
//    mcyc_o/mstb_o forced 0, state -> IDLE regardless of master cyc; master must drop cyc before re-request.
//  ARB_TIMEOUT_EN undefined: no counter; grant held indefinitely until master drops cyc.
// STRUCTURE
//  Shared package bram_bus_pkg: state encoding (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2),
//    bus width constants AW/DW/SW, default TIMEOUT_CYC.
//  Single sub-module wb_req_mux: combinational select of one master request bundle by grant.
//  FSM, last_gnt and timeout counter live in the top module.
// TESTING
//  1 Reset: assert rst async mid-cycle -> all outputs 0 same time, state IDLE.
//  2 Instr only: icyc=istb=1, iaddr=0x10 -> maddr_o=0x10 from cycle 2; BRAM ack -> iack_o=1, dack_o=0, idat_o=mdat_i.
//  3 Tie: both request from IDLE after reset -> data granted first; data drops cyc -> 1 idle cycle -> instr granted.
//  4 Lock: data holds cyc across 3 strobes while instr requests -> 3 dacks, no iack until data drops cyc.
//  5 Stray: mack_i=1 while IDLE -> iack_o=dack_o=0.
//  6 ARB_TIMEOUT_EN, TIMEOUT_CYC=4: BRAM never acks -> derr_o=1 for one cycle at 4th stalled cycle, mcyc_o=0, IDLE.

Source files
------------

// File: rtl/bram_bus_pkg.sv
// Shared definitions for the BRAM bus arbiter: bus widths, default timeout and FSM state encoding.
package bram_bus_pkg;

    localparam int unsigned BUS_AW          = 32;
    localparam int unsigned BUS_DW          = 32;
    localparam int unsigned BUS_SW          = BUS_DW / 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_req_mux.sv
// Combinational select of one Wishbone master request bundle; drives all zeros when nothing is granted.
module wb_req_mux
    import bram_bus_pkg::*;
#(
    parameter int unsigned AW = BUS_AW,
    parameter int unsigned DW = BUS_DW,
    parameter int unsigned SW = BUS_SW
) (
    input  logic          sel_instr_i,
    input  logic          sel_data_i,
    input  logic [AW-1:0] iaddr_i,
    input  logic [DW-1:0] idat_i,
    input  logic [SW-1:0] isel_i,
    input  logic          icyc_i,
    input  logic          istb_i,
    input  logic          iwe_i,
    input  logic [AW-1:0] daddr_i,
    input  logic [DW-1:0] ddat_i,
    input  logic [SW-1:0] dsel_i,
    input  logic          dcyc_i,
    input  logic          dstb_i,
    input  logic          dwe_i,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] dat_o,
    output logic [SW-1:0] sel_o,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o
);

    always_comb begin
        addr_o = '0;
        dat_o  = '0;
        sel_o  = '0;
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        we_o   = 1'b0;
        if (sel_instr_i) begin
            addr_o = iaddr_i;
            dat_o  = idat_i;
            sel_o  = isel_i;
            cyc_o  = icyc_i;
            stb_o  = istb_i;
            we_o   = iwe_i;
        end else if (sel_data_i) begin
            addr_o = daddr_i;
            dat_o  = ddat_i;
            sel_o  = dsel_i;
            cyc_o  = dcyc_i;
            stb_o  = dstb_i;
            we_o   = dwe_i;
        end
    end

endmodule

// File: rtl/bram_bus_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone-classic arbiter in front of the BRAM.
// Optional stall timeout enabled by defining ARB_TIMEOUT_EN.
module bram_bus_arbiter
    import bram_bus_pkg::*;
#(
    parameter int unsigned AW          = BUS_AW,
    parameter int unsigned DW          = BUS_DW,
    parameter int unsigned SW          = BUS_SW,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] iaddr_i,
    input  logic [DW-1:0] idat_i,
    input  logic [SW-1:0] isel_i,
    input  logic          icyc_i,
    input  logic          istb_i,
    input  logic          iwe_i,
    output logic [DW-1:0] idat_o,
    output logic          iack_o,
    output logic          ierr_o,
    input  logic [AW-1:0] daddr_i,
    input  logic [DW-1:0] ddat_i,
    input  logic [SW-1:0] dsel_i,
    input  logic          dcyc_i,
    input  logic          dstb_i,
    input  logic          dwe_i,
    output logic [DW-1:0] ddat_o,
    output logic          dack_o,
    output logic          derr_o,
    output logic [AW-1:0] maddr_o,
    output logic [DW-1:0] mdat_o,
    output logic [SW-1:0] msel_o,
    output logic          mcyc_o,
    output logic          mstb_o,
    output logic          mwe_o,
    input  logic [DW-1:0] mdat_i,
    input  logic          mack_i,
    input  logic          merr_i
);

    arb_state_e state_q, state_d;
    logic       last_data_q, last_data_d;  // 1: data master held the most recent grant
    logic       gnt_i, gnt_d, ireq, dreq;
    logic       mux_cyc, mux_stb;
    logic       timeout_hit, blk_i, blk_d;

    assign gnt_i = (state_q == StGntI);
    assign gnt_d = (state_q == StGntD);
    assign ireq  = icyc_i & istb_i & ~blk_i;
    assign dreq  = dcyc_i & dstb_i & ~blk_d;

    wb_req_mux #(
        .AW(AW),
        .DW(DW),
        .SW(SW)
    ) u_req_mux (
        .sel_instr_i(gnt_i),
        .sel_data_i (gnt_d),
        .iaddr_i    (iaddr_i),
        .idat_i     (idat_i),
        .isel_i     (isel_i),
        .icyc_i     (icyc_i),
        .istb_i     (istb_i),
        .iwe_i      (iwe_i),
        .daddr_i    (daddr_i),
        .ddat_i     (ddat_i),
        .dsel_i     (dsel_i),
        .dcyc_i     (dcyc_i),
        .dstb_i     (dstb_i),
        .dwe_i      (dwe_i),
        .addr_o     (maddr_o),
        .dat_o      (mdat_o),
        .sel_o      (msel_o),
        .cyc_o      (mux_cyc),
        .stb_o      (mux_stb),
        .we_o       (mwe_o)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            blk_i_q, blk_i_d, blk_d_q, blk_d_d;
    logic            stall;

    // A timed-out master stays locked out until it drops cyc, so a stuck cycle cannot re-grant.
    always_comb begin
        stall       = (gnt_i | gnt_d) & mux_stb & ~mack_i & ~merr_i;
        timeout_hit = stall && (cnt_q == CntW'(TIMEOUT_CYC - 1));
        cnt_d       = cnt_q;
        if (!(gnt_i | gnt_d) || mack_i || merr_i || timeout_hit) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + 1'b1;
        end
        blk_i_d = blk_i_q;
        if (timeout_hit && gnt_i) begin
            blk_i_d = 1'b1;
        end else if (!icyc_i) begin
            blk_i_d = 1'b0;
        end
        blk_d_d = blk_d_q;
        if (timeout_hit && gnt_d) begin
            blk_d_d = 1'b1;
        end else if (!dcyc_i) begin
            blk_d_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            blk_i_q <= 1'b0;
            blk_d_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blk_i_q <= blk_i_d;
            blk_d_q <= blk_d_d;
        end
    end

    assign blk_i = blk_i_q;
    assign blk_d = blk_d_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
    assign blk_i              = 1'b0;
    assign blk_d              = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        unique case (state_q)
            StIdle: begin
                if (ireq && dreq) begin
                    if (last_data_q) begin
                        state_d     = StGntI;
                        last_data_d = 1'b0;
                    end else begin
                        state_d     = StGntD;
                        last_data_d = 1'b1;
                    end
                end else if (ireq) begin
                    state_d     = StGntI;
                    last_data_d = 1'b0;
                end else if (dreq) begin
                    state_d     = StGntD;
                    last_data_d = 1'b1;
                end
            end
            StGntI: begin
                if (!icyc_i || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StGntD: begin
                if (!dcyc_i || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
        end
    end

    // Responses reach only the granted master; anything arriving while idle is dropped.
    always_comb begin
        mcyc_o = mux_cyc & ~timeout_hit;
        mstb_o = mux_stb & ~timeout_hit;
        iack_o = gnt_i & mack_i;
        ierr_o = gnt_i & (merr_i | timeout_hit);
        dack_o = gnt_d & mack_i;
        derr_o = gnt_d & (merr_i | timeout_hit);
        idat_o = (gnt_i | gnt_d) ? mdat_i : '0;
        ddat_o = (gnt_i | gnt_d) ? mdat_i : '0;
    end

endmodule

// File: tb/tb_bram_bus_arbiter.sv
// Directed, table-driven bench for bram_bus_arbiter; the timeout sequence runs when ARB_TIMEOUT_EN is set.
module tb_bram_bus_arbiter;

    localparam int OW = 139;
    localparam logic [31:0] IADDR = 32'h0000_0010;
    localparam logic [31:0] DADDR = 32'h0000_0020;
    localparam logic [31:0] IDAT  = 32'h1111_1111;
    localparam logic [31:0] DDAT  = 32'h2222_2222;
    localparam logic [3:0]  ISEL  = 4'hF;
    localparam logic [3:0]  DSEL  = 4'h3;
    localparam logic        IWE   = 1'b0;
    localparam logic        DWE   = 1'b1;

    typedef struct packed {
        logic        icyc;
        logic        istb;
        logic        dcyc;
        logic        dstb;
        logic        mack;
        logic        merr;
        logic [31:0] mdat;
        logic [1:0]  gnt;   // expected grant: 0 none, 1 instr, 2 data
        logic        iack;
        logic        dack;
        logic        ierr;
        logic        derr;
    } vec_t;

    logic        clk, rst;
    logic [31:0] iaddr_i, idat_i, daddr_i, ddat_i, idat_o, ddat_o;
    logic [3:0]  isel_i, dsel_i, msel_o;
    logic        icyc_i, istb_i, iwe_i, dcyc_i, dstb_i, dwe_i;
    logic        iack_o, ierr_o, dack_o, derr_o;
    logic [31:0] maddr_o, mdat_o, mdat_i;
    logic        mcyc_o, mstb_o, mwe_o, mack_i, merr_i;
    logic [OW-1:0] got_bus;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[24];

    bram_bus_arbiter #(
        .AW(32),
        .DW(32),
        .SW(4),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iaddr_i(iaddr_i),
        .idat_i (idat_i),
        .isel_i (isel_i),
        .icyc_i (icyc_i),
        .istb_i (istb_i),
        .iwe_i  (iwe_i),
        .idat_o (idat_o),
        .iack_o (iack_o),
        .ierr_o (ierr_o),
        .daddr_i(daddr_i),
        .ddat_i (ddat_i),
        .dsel_i (dsel_i),
        .dcyc_i (dcyc_i),
        .dstb_i (dstb_i),
        .dwe_i  (dwe_i),
        .ddat_o (ddat_o),
        .dack_o (dack_o),
        .derr_o (derr_o),
        .maddr_o(maddr_o),
        .mdat_o (mdat_o),
        .msel_o (msel_o),
        .mcyc_o (mcyc_o),
        .mstb_o (mstb_o),
        .mwe_o  (mwe_o),
        .mdat_i (mdat_i),
        .mack_i (mack_i),
        .merr_i (merr_i)
    );

    assign got_bus = {maddr_o, mdat_o, msel_o, mcyc_o, mstb_o, mwe_o,
                      iack_o, dack_o, ierr_o, derr_o, idat_o, ddat_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic icyc, input logic istb, input logic dcyc,
                               input logic dstb, input logic mack, input logic merr,
                               input logic [31:0] mdat, input logic [1:0] gnt,
                               input logic iack, input logic dack, input logic ierr,
                               input logic derr);
        vec_t r;
        r = '{icyc, istb, dcyc, dstb, mack, merr, mdat, gnt, iack, dack, ierr, derr};
        return r;
    endfunction

    function automatic logic [OW-1:0] expect_bus(input vec_t t);
        logic [31:0] rd;
        logic [OW-1:0] r;
        rd = (t.gnt != 2'd0) ? t.mdat : 32'h0;
        if (t.gnt == 2'd1) begin
            r = {IADDR, IDAT, ISEL, t.icyc, t.istb, IWE,
                 t.iack, t.dack, t.ierr, t.derr, rd, rd};
        end else if (t.gnt == 2'd2) begin
            r = {DADDR, DDAT, DSEL, t.dcyc, t.dstb, DWE,
                 t.iack, t.dack, t.ierr, t.derr, rd, rd};
        end else begin
            r = {{(OW-64){1'b0}}, t.iack, t.dack, t.ierr, t.derr, 64'h0} >> 0;
            r = '0;
            r[67:64] = {t.iack, t.dack, t.ierr, t.derr};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        icyc_i = t.icyc;
        istb_i = t.istb;
        dcyc_i = t.dcyc;
        dstb_i = t.dstb;
        mack_i = t.mack;
        merr_i = t.merr;
        mdat_i = t.mdat;
    endtask

    // Advance one clock and land mid-cycle for sampling.
    task automatic step();
        @(posedge clk);
        #4;
    endtask

    initial begin
        // icyc istb dcyc dstb mack merr mdat          gnt iack dack ierr derr
        vecs[0]  = v(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0);
        vecs[1]  = v(1, 1, 0, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0);
        vecs[2]  = v(1, 1, 0, 0, 1, 0, 32'hA5A5_0001,  1, 1, 0, 0, 0);
        vecs[3]  = v(0, 0, 0, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0);
        vecs[4]  = v(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0);
        vecs[5]  = v(0, 0, 0, 0, 1, 1, 32'hFFFF_0000,  0, 0, 0, 0, 0);
        vecs[6]  = v(1, 1, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0);
        vecs[7]  = v(1, 1, 1, 1, 0, 0, 32'h0,          2, 0, 0, 0, 0);
        vecs[8]  = v(1, 1, 1, 1, 1, 0, 32'h1234_5678,  2, 0, 1, 0, 0);
        vecs[9]  = v(1, 1, 0, 0, 0, 0, 32'h0,          2, 0, 0, 0, 0);
        vecs[10] = v(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0);
        vecs[11] = v(1, 1, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0);
        vecs[12] = v(1, 1, 1, 1, 1, 1, 32'hCAFE_F00D,  1, 1, 0, 1, 0);
        vecs[13] = v(0, 0, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0);
        vecs[14] = v(0, 0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0);
        vecs[15] = v(1, 1, 1, 1, 1, 0, 32'h0000_0011,  2, 0, 1, 0, 0);
        vecs[16] = v(1, 1, 1, 0, 0, 0, 32'h0,          2, 0, 0, 0, 0);
        vecs[17] = v(1, 1, 1, 1, 1, 0, 32'h0000_0022,  2, 0, 1, 0, 0);
        vecs[18] = v(1, 1, 1, 1, 1, 0, 32'h0000_0033,  2, 0, 1, 0, 0);
        vecs[19] = v(1, 1, 0, 0, 0, 0, 32'h0,          2, 0, 0, 0, 0);
        vecs[20] = v(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0);
        vecs[21] = v(1, 1, 0, 0, 1, 0, 32'h0000_0044,  1, 1, 0, 0, 0);
        vecs[22] = v(0, 0, 0, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0);
        vecs[23] = v(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0);

        iaddr_i = IADDR;
        idat_i  = IDAT;
        isel_i  = ISEL;
        iwe_i   = IWE;
        daddr_i = DADDR;
        ddat_i  = DDAT;
        dsel_i  = DSEL;
        dwe_i   = DWE;
        drive(v(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        check("reset_outputs", got_bus, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i]);
            #4;
            check($sformatf("vec%0d", i), got_bus, expect_bus(vecs[i]));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a data transaction.
        drive(v(0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("rst_pre_grant", OW'({mcyc_o, maddr_o}), OW'({1'b1, DADDR}));
        mack_i = 1'b1;
        mdat_i = 32'h5A5A_5A5A;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_mid", got_bus, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Tie straight out of reset: data first, one idle cycle, then instruction.
        drive(v(1, 1, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));
        #3;
        check("tie_idle", got_bus, '0);
        step();
        check("tie_first_data", OW'({mcyc_o, mstb_o, maddr_o}), OW'({2'b11, DADDR}));
        dcyc_i = 1'b0;
        dstb_i = 1'b0;
        step();
        check("tie_gap", got_bus, '0);
        step();
        check("tie_second_instr", OW'({mcyc_o, mstb_o, maddr_o}), OW'({2'b11, IADDR}));
        icyc_i = 1'b0;
        istb_i = 1'b0;
        step();
        step();
        check("idle_after_tie", got_bus, '0);

`ifdef ARB_TIMEOUT_EN
        // BRAM never answers: error on the 4th stalled cycle, then master locked out until cyc drops.
        dcyc_i = 1'b1;
        dstb_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("to_stall%0d", c), OW'({mcyc_o, derr_o, ierr_o}), OW'(3'b100));
        end
        step();
        check("to_error", OW'({mcyc_o, mstb_o, derr_o, ierr_o, dack_o}), OW'(5'b00100));
        step();
        check("to_idle", got_bus, '0);
        step();
        check("to_locked", got_bus, '0);
        dcyc_i = 1'b0;
        dstb_i = 1'b0;
        step();
        dcyc_i = 1'b1;
        dstb_i = 1'b1;
        step();
        step();
        check("to_regrant", OW'({mcyc_o, maddr_o}), OW'({1'b1, DADDR}));
        dcyc_i = 1'b0;
        dstb_i = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
